// File: rtl/control.sv
// Main decoder for the ID stage: maps a 5-bit opcode to 13 registered control lines.
// A hazard or reset inserts a bubble by registering all lines low.
module control (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic       hazard,
  output logic       branch,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrc,
  output logic       aluop,
  output logic       regdist,
  output logic       branchtype,
  output logic       push,
  output logic       pop,
  output logic       ret,
  output logic       jump
);

  typedef struct packed {
    logic branch;
    logic regwrite;
    logic memtoreg;
    logic memread;
    logic memwrite;
    logic alusrc;
    logic aluop;
    logic regdist;
    logic branchtype;
    logic push;
    logic pop;
    logic ret;
    logic jump;
  } ctl_t;

  ctl_t dec;
  ctl_t q;

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (opcode < 5'd8): begin
        dec.regwrite = 1'b1;
        dec.regdist  = 1'b1;
        dec.aluop    = 1'b1;
      end
      (opcode == 5'd8): begin
        dec.branch = 1'b1;
        dec.aluop  = 1'b1;
      end
      (opcode == 5'd9): begin
        dec.branch     = 1'b1;
        dec.aluop      = 1'b1;
        dec.branchtype = 1'b1;
      end
      (opcode == 5'd10): begin
        dec.jump = 1'b1;
      end
      (opcode == 5'd11): begin
        dec.jump     = 1'b1;
        dec.push     = 1'b1;
        dec.memwrite = 1'b1;
      end
      (opcode == 5'd12): begin
        dec.ret     = 1'b1;
        dec.pop     = 1'b1;
        dec.memread = 1'b1;
      end
      (opcode == 5'd13): begin
        dec.regwrite = 1'b1;
        dec.memtoreg = 1'b1;
        dec.memread  = 1'b1;
        dec.alusrc   = 1'b1;
      end
      (opcode == 5'd14): begin
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      (opcode == 5'd15): begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      (opcode == 5'd16): begin
        dec.push     = 1'b1;
        dec.memwrite = 1'b1;
      end
      (opcode == 5'd17): begin
        dec.pop      = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (hazard) begin
      q <= '0;
    end else begin
      q <= dec;
    end
  end

  assign branch     = q.branch;
  assign regwrite   = q.regwrite;
  assign memtoreg   = q.memtoreg;
  assign memread    = q.memread;
  assign memwrite   = q.memwrite;
  assign alusrc     = q.alusrc;
  assign aluop      = q.aluop;
  assign regdist    = q.regdist;
  assign branchtype = q.branchtype;
  assign push       = q.push;
  assign pop        = q.pop;
  assign ret        = q.ret;
  assign jump       = q.jump;

endmodule

// File: tb/tb_control.sv
// Randomized bench for control: an opcode-class model predicts each edge's outputs,
// with literal checks pinning the directed cases.
module tb_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic       hazard;
  logic branch, regwrite, memtoreg, memread, memwrite, alusrc, aluop;
  logic regdist, branchtype, push, pop, ret, jump;

  int checks = 0;
  int errors = 0;

  control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .hazard(hazard),
    .branch(branch), .regwrite(regwrite), .memtoreg(memtoreg),
    .memread(memread), .memwrite(memwrite), .alusrc(alusrc),
    .aluop(aluop), .regdist(regdist), .branchtype(branchtype),
    .push(push), .pop(pop), .ret(ret), .jump(jump)
  );

  always #5 clk = ~clk;

  wire [12:0] outv = {branch, regwrite, memtoreg, memread, memwrite,
                      alusrc, aluop, regdist, branchtype, push, pop,
                      ret, jump};

  // Each output is the set of opcodes that asserts it.
  function automatic logic [12:0] model(input int op);
    logic b, rw, mr, rd, wr, as, ao, rdst, bt, pu, po, rt, j;
    b    = (op == 8 || op == 9);
    rw   = (op <= 7 || op == 13 || op == 15 || op == 17);
    mr   = (op == 13 || op == 17);
    rd   = (op == 12 || op == 13 || op == 17);
    wr   = (op == 11 || op == 14 || op == 16);
    as   = (op == 13 || op == 14 || op == 15);
    ao   = (op <= 9);
    rdst = (op <= 7);
    bt   = (op == 9);
    pu   = (op == 11 || op == 16);
    po   = (op == 12 || op == 17);
    rt   = (op == 12);
    j    = (op == 10 || op == 11);
    return {b, rw, mr, rd, wr, as, ao, rdst, bt, pu, po, rt, j};
  endfunction

  logic [12:0] expv;
  logic        valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      expv  <= '0;
      valid <= 1'b1;
    end else if (hazard) begin
      expv <= '0;
    end else begin
      expv <= model(int'(opcode));
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (outv !== expv) begin
        errors++;
        $display("FAIL model t=%0t got=%b want=%b", $time, outv, expv);
      end
      checks++;
      if ((memread && memwrite) || (push && pop) ||
          (branch && jump) || (memtoreg && !memread)) begin
        errors++;
        $display("FAIL invariant t=%0t got=%b want=consistent", $time, outv);
      end
    end
  end

  task automatic cyc(input logic r, input int op, input logic h);
    rst    = r;
    opcode = op[4:0];
    hazard = h;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [12:0] want);
    checks++;
    if (outv !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, outv, want);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = 5'd13; hazard = 1'b0;
    @(negedge clk);
    cyc(1'b1, 13, 1'b0); lit("reset1", 13'b0);
    cyc(1'b1, 13, 1'b0); lit("reset2", 13'b0);
    cyc(1'b0, 13, 1'b0); lit("ld", 13'b0111010000000);
    cyc(1'b0, 8, 1'b0);  lit("beq", 13'b1000001000000);
    cyc(1'b0, 9, 1'b0);  lit("bne", 13'b1000001010000);
    cyc(1'b0, 10, 1'b0); lit("jmp", 13'b0000000000001);
    cyc(1'b0, 11, 1'b0); lit("call", 13'b0000100001001);
    cyc(1'b0, 12, 1'b0); lit("ret", 13'b0001000000110);
    for (int op = 8; op <= 11; op++) begin
      cyc(1'b0, op, 1'b1);
      lit($sformatf("hazard_%0d", op), 13'b0);
    end
    for (int op = 0; op < 32; op++) cyc(1'b0, op, 1'b0);
    cyc(1'b0, 5, 1'b0);  lit("add", 13'b0100001100000);
    cyc(1'b1, 13, 1'b0); lit("midreset", 13'b0);
    cyc(1'b0, 0, 1'b0);  lit("postreset", 13'b0100001100000);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), int'($urandom_range(31)),
          ($urandom_range(7) == 0));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
